// File: rtl/fp_mult_arbiter.sv
// Round-robin arbiter that shares one combinational single-precision multiplier among NUM_REQ
// requesters. Define FP_MULT_ARB_INREG_EN to add a pipeline stage (state MUL) after the multiplier.
module fp_mult_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_result,
    output logic                   busy
);

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
`ifdef FP_MULT_ARB_INREG_EN
        StMul,
`endif
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   grant;
    logic              grant_found;
    logic              accept;
    logic [31:0]       op_a_q, op_b_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [31:0]       rsp_result_q;
`ifdef FP_MULT_ARB_INREG_EN
    logic [31:0]       mul_q;
`endif

    // IEEE-754 single multiply, round-to-nearest-even, subnormals supported, NaN -> 7fc00000.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb;
        logic [47:0] prod, norm;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic        sticky, round_up;
        logic [30:0] mag;
        int          msb, exp_r, shamt;
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        ma     = {|ea, a[22:0]};
        mb     = {|eb, b[22:0]};
        a_nan  = (ea == 8'hff) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hff) && (b[22:0] != 23'd0);
        a_inf  = (ea == 8'hff) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hff) && (b[22:0] == 23'd0);
        a_zero = (a[30:0] == 31'd0);
        b_zero = (b[30:0] == 31'd0);
        prod   = 48'(ma) * 48'(mb);
        msb    = 0;
        for (int i = 0; i < 48; i++) begin
            if (prod[i]) msb = i;
        end
        norm   = prod << (47 - msb);
        exp_r  = ((ea == 8'd0) ? 1 : int'(ea)) + ((eb == 8'd0) ? 1 : int'(eb)) - 126 - (47 - msb);
        sticky = 1'b0;
        // Underflow: denormalise so the encoded exponent is 0, keeping shifted-out bits as sticky.
        if (exp_r <= 0) begin
            shamt = 1 - exp_r;
            if (shamt >= 48) begin
                sticky = |norm;
                norm   = '0;
            end else begin
                sticky = |(norm & ((48'd1 << shamt) - 48'd1));
                norm   = norm >> shamt;
            end
            exp_r = 0;
        end
        round_up = norm[23] & (sticky | (|norm[22:0]) | norm[24]);
        mag      = {exp_r[7:0], norm[46:24]} + 31'(round_up);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            fp_mul = 32'h7fc0_0000;
        end else if (a_inf || b_inf) begin
            fp_mul = {sign, 8'hff, 23'd0};
        end else if (a_zero || b_zero) begin
            fp_mul = {sign, 31'd0};
        end else if (exp_r >= 255) begin
            fp_mul = {sign, 8'hff, 23'd0};
        end else begin
            fp_mul = {sign, mag};
        end
    endfunction

    // Search starts just above the last winner and wraps.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!grant_found && req_valid[(32'(ptr_q) + i) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant       = ID_W'((32'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    assign accept = (state_q == StIdle) && grant_found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StCompute;
`ifdef FP_MULT_ARB_INREG_EN
            StCompute: state_d = StMul;
            StMul:     state_d = StResp;
`else
            StCompute: state_d = StResp;
`endif
            StResp:    if (rsp_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant] = 1'b1;
        rsp_valid  = (state_q == StResp);
        busy       = (state_q != StIdle);
        rsp_id     = rsp_id_q;
        rsp_result = rsp_result_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= ID_W'(NUM_REQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
`ifdef FP_MULT_ARB_INREG_EN
            mul_q        <= '0;
`endif
        end else begin
            if (accept) begin
                op_a_q   <= req_a[32*grant +: 32];
                op_b_q   <= req_b[32*grant +: 32];
                rsp_id_q <= grant;
                ptr_q    <= grant;
            end
`ifdef FP_MULT_ARB_INREG_EN
            if (state_q == StCompute) mul_q        <= fp_mul(op_a_q, op_b_q);
            if (state_q == StMul)     rsp_result_q <= mul_q;
`else
            if (state_q == StCompute) rsp_result_q <= fp_mul(op_a_q, op_b_q);
`endif
        end
    end

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Scoreboard bench for fp_mult_arbiter: directed operand vectors, expected grants and products
// queued at issue time, a driver and a monitor checking independently.
module tb_fp_mult_arbiter;

    localparam int N = 4;
`ifdef FP_MULT_ARB_INREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] res;
    } rsp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a, req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_result;
    logic            busy;

    fp_mult_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;
    rsp_t        exp_q[$];
    int          exp_grant[$];
    int          acc_q[$];
    int          rsp_cyc_q[$];
    logic [31:0] op_a [N][8];
    logic [31:0] op_b [N][8];
    int          n_ops [N];
    int          idx [N];
    logic [N-1:0] drv_fire;
    logic         prev_v = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            if (idx[i] < n_ops[i]) begin
                req_valid[i]      = 1'b1;
                req_a[32*i +: 32] = op_a[i][idx[i]];
                req_b[32*i +: 32] = op_b[i][idx[i]];
            end else begin
                req_valid[i]      = 1'b0;
                req_a[32*i +: 32] = '0;
                req_b[32*i +: 32] = '0;
            end
        end
    endtask

    task automatic add_op(input int r, input logic [31:0] a, input logic [31:0] b);
        op_a[r][n_ops[r]] = a;
        op_b[r][n_ops[r]] = b;
        n_ops[r]++;
    endtask

    task automatic expect_op(input int id, input logic [31:0] res);
        exp_grant.push_back(id);
        exp_q.push_back({2'(id), res});
    endtask

    function automatic bit all_consumed();
        for (int i = 0; i < N; i++) if (idx[i] != n_ops[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && all_consumed() && !busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s_timeout: got pending=%0d expected pending=0", name, exp_q.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_req_ready"}, 32'(req_ready), 32'd0);
        check({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_rsp_id"}, 32'(rsp_id), 32'd0);
        check({name, "_rsp_result"}, rsp_result, 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
    endtask

    // Driver: a requester advances to its next operand pair once its handshake completes.
    initial begin
        forever begin
            @(negedge clk);
            drv_fire = req_valid & req_ready;
            if (drv_fire != '0) begin
                int g = 0;
                check("grant_onehot", 32'($countones(drv_fire)), 32'd1);
                for (int i = 0; i < N; i++) if (drv_fire[i]) g = i;
                if (exp_grant.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected: got %0d expected none", g);
                end else begin
                    check("grant_order", 32'(g), 32'(exp_grant.pop_front()));
                end
                acc_q.push_back(cyc);
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (drv_fire[i]) idx[i]++;
            refresh();
        end
    end

    // Monitor: latency on rsp_valid rise, id/result on each response handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_v) begin
                if (acc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_no_accept: got rsp_valid=1 expected 0");
                end else begin
                    check("rsp_latency", 32'(cyc - acc_q.pop_front()), 32'(LAT));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got id %0d result %h expected none",
                             rsp_id, rsp_result);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_result", rsp_result, e.res);
                end
                rsp_cyc_q.push_back(cyc);
            end
            prev_v = rsp_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < N; i++) begin
            n_ops[i] = 0;
            idx[i]   = 0;
        end
        do_reset();

        // 1.5 * 1.5 from requester 0
        @(posedge clk); #2;
        expect_op(0, 32'h4010_0000);
        add_op(0, 32'h3fc0_0000, 32'h3fc0_0000);
        refresh();
        wait_done("t1");

        // requesters 1 and 3 together after reset: 1 wins first
        do_reset();
        @(posedge clk); #2;
        expect_op(1, 32'h4000_0000);
        expect_op(3, 32'h4000_0000);
        add_op(1, 32'h3f80_0000, 32'h4000_0000);
        add_op(3, 32'h3f80_0000, 32'h4000_0000);
        refresh();
        wait_done("t2");

        // all four valid: rotation 0,1,2,3,0 with mixed numerics
        rsp_cyc_q.delete();
        @(posedge clk); #2;
        expect_op(0, 32'h4040_0000);
        expect_op(1, 32'hc0c0_0000);
        expect_op(2, 32'h0040_0000);
        expect_op(3, 32'h7fc0_0000);
        expect_op(0, 32'h7f80_0000);
        add_op(0, 32'h3f80_0000, 32'h4040_0000);
        add_op(0, 32'h7f00_0000, 32'h7f00_0000);
        add_op(1, 32'hc000_0000, 32'h4040_0000);
        add_op(2, 32'h0080_0000, 32'h3f00_0000);
        add_op(3, 32'h7fc0_0000, 32'h3f80_0000);
        refresh();
        wait_done("t3");
        check("t3_rsp_count", 32'(rsp_cyc_q.size()), 32'd5);
        for (int k = 1; k < rsp_cyc_q.size(); k++) begin
            check("t3_rsp_interval", 32'(rsp_cyc_q[k] - rsp_cyc_q[k-1]), 32'(LAT + 1));
        end

        // stalled response: -0 held while requester 0 waits
        @(posedge clk); #2;
        rsp_ready = 1'b0;
        expect_op(2, 32'h8000_0000);
        expect_op(0, 32'h7fc0_0000);
        add_op(2, 32'h8000_0000, 32'h3fc0_0000);
        add_op(0, 32'h7f80_0000, 32'h0000_0000);
        refresh();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #2;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_rsp_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("t4_rsp_valid", 32'(rsp_valid), 32'd1);
            check("t4_rsp_result", rsp_result, 32'h8000_0000);
            check("t4_rsp_id", 32'(rsp_id), 32'd2);
            check("t4_req_ready", 32'(req_ready), 32'd0);
            check("t4_busy", 32'(busy), 32'd1);
            @(negedge clk); #2;
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_done("t4");

        // reset during COMPUTE discards the op and restores the pointer
        @(posedge clk); #2;
        exp_grant.push_back(0);
        add_op(0, 32'h3fc0_0000, 32'h3fc0_0000);
        refresh();
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #2;
            if (busy) begin
                seen = 1'b1;
                break;
            end
        end
        check("t5_busy_seen", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        acc_q.delete();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #2;
            check("t5_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #2;
        expect_op(0, 32'h4010_0000);
        expect_op(1, 32'h4000_0000);
        add_op(0, 32'h3fc0_0000, 32'h3fc0_0000);
        add_op(1, 32'h3f80_0000, 32'h4000_0000);
        refresh();
        wait_done("t5");
        check("end_grants_left", 32'(exp_grant.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
